// File: rtl/sm_regdump.sv
// sm_regdump: dumps regs REG_FIRST..REG_LAST as 5-byte frames on a byte stream; define SM_REGDUMP_CHECKSUM_EN to append an XOR byte
module sm_regdump #(
  parameter int ADDR_WIDTH = 5,
  parameter int REG_FIRST = 0,
  parameter int REG_LAST = 31
) (
  input  logic                  clk,
  input  logic                  rst_p,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] regAddr,
  input  logic [31:0]           regData,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);
  localparam logic [1:0] IDLE = 2'd0, CAPTURE = 2'd1, SEND = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] FIRST = ADDR_WIDTH'(REG_FIRST), LAST = ADDR_WIDTH'(REG_LAST);
  logic [1:0] state;
  logic [2:0] idx;
  logic [31:0] shadow;
  logic settle, xfer, lastByte;
  assign xfer = out_valid & out_ready;
  assign lastByte = idx == 3'd4;
`ifdef SM_REGDUMP_CHECKSUM_EN
  localparam logic [1:0] CSUM = 2'd3;
  logic [7:0] csum;
  always_ff @(posedge clk)
    csum <= (rst_p || (state == IDLE && start)) ? 8'd0 : xfer ? csum ^ out_data : csum;
`endif
  always_ff @(posedge clk)
    if (rst_p) begin
      regAddr <= FIRST;
      out_data <= '0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      state <= IDLE;
      idx <= '0;
      shadow <= '0;
      settle <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          regAddr <= FIRST;
          busy <= 1'b1;
          settle <= 1'b1;
          state <= CAPTURE;
        end
        CAPTURE: if (settle) settle <= 1'b0;
        else begin
          shadow <= regData;
          out_data <= 8'(regAddr);
          out_valid <= 1'b1;
          idx <= '0;
          state <= SEND;
        end
        SEND: if (xfer) begin
          idx <= idx + 3'd1;
          if (!lastByte) begin
            out_data <= shadow[31:24];
            shadow <= shadow << 8;
          end else if (regAddr != LAST) begin
            out_valid <= 1'b0;
            regAddr <= regAddr + 1'b1;
            state <= CAPTURE;
          end else begin
`ifdef SM_REGDUMP_CHECKSUM_EN
            out_data <= csum ^ out_data;
            state <= CSUM;
`else
            out_valid <= 1'b0;
            done <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
`endif
          end
        end
`ifdef SM_REGDUMP_CHECKSUM_EN
        CSUM: if (xfer) begin
          out_valid <= 1'b0;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sm_regdump.sv
// tb_sm_regdump: scoreboard bench for sm_regdump; expected bytes queued by stimulus, popped by per-DUT monitors
module tb_sm_regdump;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int vectors = 0, errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  logic startA = 0, readyA = 1, validA, busyA, doneA;
  logic [4:0] addrA;
  logic [7:0] dataA;
  logic [31:0] rdA;
  assign rdA = addrA == 5'd1 ? 32'h12345678 : addrA == 5'd2 ? 32'hDEADBEEF : 32'h0;
  sm_regdump #(.ADDR_WIDTH(5), .REG_FIRST(0), .REG_LAST(2)) dutA (
    .clk(clk), .rst_p(rst), .start(startA), .regAddr(addrA), .regData(rdA),
    .out_data(dataA), .out_valid(validA), .out_ready(readyA), .busy(busyA), .done(doneA));

  logic startB = 0, readyB = 1, validB, busyB, doneB;
  logic [3:0] addrB;
  logic [7:0] dataB;
  logic [31:0] rdB = 32'h0;
  sm_regdump #(.ADDR_WIDTH(4), .REG_FIRST(15), .REG_LAST(15)) dutB (
    .clk(clk), .rst_p(rst), .start(startB), .regAddr(addrB), .regData(rdB),
    .out_data(dataB), .out_valid(validB), .out_ready(readyB), .busy(busyB), .done(doneB));

  logic startC = 0, readyC = 1, validC, busyC, doneC;
  logic [4:0] addrC;
  logic [7:0] dataC;
  logic [31:0] rdC;
  assign rdC = addrC == 5'd1 ? 32'h01020304 : addrC == 5'd2 ? 32'h000000FF : 32'h0;
  sm_regdump #(.ADDR_WIDTH(5), .REG_FIRST(1), .REG_LAST(2)) dutC (
    .clk(clk), .rst_p(rst), .start(startC), .regAddr(addrC), .regData(rdC),
    .out_data(dataC), .out_valid(validC), .out_ready(readyC), .busy(busyC), .done(doneC));

  logic [7:0] qA[$], qB[$], qC[$];
  int doneAn = 0, doneBn = 0, doneCn = 0, xferA = 0, xferB = 0;
  logic stallA = 0, stallB = 0, stallC = 0;
  logic [7:0] holdA, holdB, holdC;

  always @(negedge clk) begin
    if (stallA && !rst) begin chk("holdA_valid", validA, 1); chk("holdA_data", dataA, holdA); end
    stallA = validA && !readyA && !rst;
    holdA = dataA;
    if (validA && readyA && !rst) begin
      xferA++;
      if (qA.size() == 0) begin vectors++; errors++; $display("FAIL byteA: got extra %h expected none", dataA); end
      else chk("byteA", dataA, qA.pop_front());
    end
    if (doneA) begin
      doneAn++;
      chk("busyA_with_done", busyA, 0);
      chk("qA_empty_at_done", qA.size(), 0);
    end
  end

  always @(negedge clk) begin
    if (stallB && !rst) begin chk("holdB_valid", validB, 1); chk("holdB_data", dataB, holdB); end
    stallB = validB && !readyB && !rst;
    holdB = dataB;
    if (validB && readyB && !rst) begin
      xferB++;
      chk("addrB_nowrap", addrB, 4'hF);
      if (qB.size() == 0) begin vectors++; errors++; $display("FAIL byteB: got extra %h expected none", dataB); end
      else chk("byteB", dataB, qB.pop_front());
    end
    if (doneB) begin
      doneBn++;
      chk("busyB_with_done", busyB, 0);
      chk("qB_empty_at_done", qB.size(), 0);
    end
  end

  always @(negedge clk) begin
    if (stallC && !rst) begin chk("holdC_valid", validC, 1); chk("holdC_data", dataC, holdC); end
    stallC = validC && !readyC && !rst;
    holdC = dataC;
    if (validC && readyC && !rst) begin
      if (qC.size() == 0) begin vectors++; errors++; $display("FAIL byteC: got extra %h expected none", dataC); end
      else chk("byteC", dataC, qC.pop_front());
    end
    if (doneC) begin
      doneCn++;
      chk("busyC_with_done", busyC, 0);
      chk("qC_empty_at_done", qC.size(), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input int which, input int n);
    for (int i = 0; i < 400; i++) begin
      tick();
      if ((which == 0 ? doneAn : which == 1 ? doneBn : doneCn) >= n) return;
    end
    vectors++;
    errors++;
    $display("FAIL timeout_dut%0d: got no done expected done #%0d", which, n);
  endtask

  task automatic pushA();
    qA = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
          8'h01, 8'h12, 8'h34, 8'h56, 8'h78,
          8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
  endtask

  bit patt[6] = '{1, 0, 0, 1, 0, 1};

  initial begin
    repeat (3) tick();
    rst = 0;
    chk("rst_validA", validA, 0);
    chk("rst_dataA", dataA, 0);
    chk("rst_busyA", busyA, 0);
    chk("rst_doneA", doneA, 0);
    chk("rst_addrA", addrA, 0);
    chk("rst_addrB", addrB, 4'hF);
    chk("rst_addrC", addrC, 1);

    pushA();
    startA = 1;
    tick();
    startA = 0;
    chk("busyA_k", busyA, 1);
    chk("validA_k", validA, 0);
    tick();
    chk("validA_k1", validA, 0);
    tick();
    chk("validA_k2", validA, 1);
    chk("firstA_byte", dataA, 8'h00);
    waitDone(0, 1);
    repeat (3) tick();
    chk("doneA_once", doneAn, 1);
    chk("busyA_idle", busyA, 0);
    chk("addrA_last", addrA, 2);

    qB = {8'h0F, 8'hA5, 8'hA5, 8'h0F, 8'h0F};
    rdB = 32'hA5A50F0F;
    xferB = 0;
    startB = 1;
    tick();
    startB = 0;
    for (int i = 0; i < 100 && doneBn < 1; i++) begin
      readyB = patt[i % 6];
      tick();
    end
    readyB = 1;
    repeat (2) tick();
    chk("doneB_bp", doneBn, 1);
    chk("xferB_bp", xferB, 5);

    qB = {8'h0F, 8'hC1, 8'hFE, 8'hEF, 8'h01};
    xferB = 0;
    startB = 1;
    tick();
    startB = 0;
    for (int i = 0; i < 60 && doneBn < 2; i++) begin
      rdB = 32'hC0FFEE00 ^ {4{8'(i)}};
      readyB = i >= 2 && i < 7 ? 1'b0 : 1'b1;
      tick();
    end
    readyB = 1;
    repeat (2) tick();
    chk("doneB_snap", doneBn, 2);
    chk("xferB_snap", xferB, 5);
    chk("addrB_end", addrB, 4'hF);

    pushA();
    xferA = 0;
    startA = 1;
    tick();
    startA = 0;
    for (int i = 0; i < 100 && xferA < 7; i++) tick();
    chk("xferA_before_rst", xferA, 7);
    rst = 1;
    tick();
    rst = 0;
    chk("validA_after_rst", validA, 0);
    chk("addrA_after_rst", addrA, 0);
    chk("busyA_after_rst", busyA, 0);
    qA.delete();
    repeat (2) tick();
    pushA();
    startA = 1;
    tick();
    startA = 0;
    waitDone(0, 2);
    repeat (2) tick();
    chk("doneA_after_rst", doneAn, 2);

    pushA();
    startA = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (doneA) break;
    end
    startA = 0;
    repeat (10) tick();
    chk("doneA_held", doneAn, 3);
    chk("busyA_held", busyA, 0);
    chk("qA_held_empty", qA.size(), 0);

    qC = {8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h02, 8'h00, 8'h00, 8'h00, 8'hFF};
`ifdef SM_REGDUMP_CHECKSUM_EN
    qC.push_back(8'hF8);
`endif
    startC = 1;
    tick();
    startC = 0;
    waitDone(2, 1);
    repeat (2) tick();
    chk("doneC_once", doneCn, 1);
    chk("qC_empty", qC.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
